// File: rtl/kiwi_snd_pkg.sv
// Shared constants and the saturation helper for the Kiwi sound glue block.
package kiwi_snd_pkg;

  localparam logic [7:0] GAIN_UNITY = 8'h10;
  localparam logic [7:0] FM_GAIN    = 8'h10;
  localparam logic [7:0] PSG_GAIN   = 8'h10;

  localparam int NUM_CH = 4;
  localparam int SUM_W  = 22;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 22'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -22'sd32768;

  typedef struct packed {
    logic        pk;
    logic [15:0] smp;
  } mix_t;

  function automatic mix_t sat16(input logic signed [SUM_W-1:0] s);
    mix_t r;
    r.pk  = 1'b0;
    r.smp = s[15:0];
    if (s > SAT_MAX) begin
      r.pk  = 1'b1;
      r.smp = 16'h7FFF;
    end else if (s < SAT_MIN) begin
      r.pk  = 1'b1;
      r.smp = 16'h8000;
    end
    return r;
  endfunction

endpackage

// File: rtl/kiwi_edge_ff.sv
// Set/clear flip-flop: a set pulse wins over a simultaneous clear.
module kiwi_edge_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic sigedge,
  input  logic clr,
  output logic q,
  output logic qn
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_q <= 1'b0;
    else if (sigedge) r_q <= 1'b1;
    else if (clr)     r_q <= 1'b0;
  end

  assign q  = r_q;
  assign qn = ~r_q;

endmodule

// File: rtl/kiwi_snd_glue.sv
// Four-channel gain/mix/saturate audio path plus the vertical-blank interrupt.
module kiwi_snd_glue
  import kiwi_snd_pkg::*;
#(
  parameter int W0 = 16,
  parameter int W1 = 10,
  parameter int W2 = 16,
  parameter int W3 = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [W0-1:0] ch0,
  input  logic [W1-1:0] ch1,
  input  logic [W2-1:0] ch2,
  input  logic [W3-1:0] ch3,
  input  logic [7:0]    gain0,
  input  logic [7:0]    gain1,
  input  logic [7:0]    gain2,
  input  logic [7:0]    gain3,
  output logic [15:0]   mixed,
  output logic          peak,
  input  logic          lvbl,
  input  logic          irq_ack,
  output logic          int_n
);

  logic signed [15:0]      w_a [NUM_CH];
  logic        [7:0]       w_g [NUM_CH];
  logic signed [23:0]      w_p [NUM_CH];
  logic signed [19:0]      w_t [NUM_CH];
  logic signed [SUM_W-1:0] w_sum;
  mix_t                    w_mix;

  // Narrow channels are left-aligned so full scale is full scale for all.
  assign w_a[0] = 16'($signed(ch0)) << (16 - W0);
  assign w_a[1] = 16'($signed(ch1)) << (16 - W1);
  assign w_a[2] = 16'($signed(ch2)) << (16 - W2);
  assign w_a[3] = 16'($signed(ch3)) << (16 - W3);

  assign w_g[0] = gain0;
  assign w_g[1] = gain1;
  assign w_g[2] = gain2;
  assign w_g[3] = gain3;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_p[i] = 24'(w_a[i]) * 24'($signed({1'b0, w_g[i]}));
    assign w_t[i] = 20'(w_p[i] >>> 4);
  end

  assign w_sum = SUM_W'(w_t[0]) + SUM_W'(w_t[1]) + SUM_W'(w_t[2]) + SUM_W'(w_t[3]);
  assign w_mix = sat16(w_sum);

  logic [15:0] r_mixed;
  logic        r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mixed <= 16'h0000;
      r_peak  <= 1'b0;
    end else if (cen) begin
      r_mixed <= w_mix.smp;
      r_peak  <= w_mix.pk;
    end
  end

  assign mixed = r_mixed;
  assign peak  = r_peak;

  // r_seen1 blocks a false edge when lvbl is already low at reset release.
  logic r_lvbl;
  logic r_seen1;
  logic w_edge;
  logic w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvbl  <= 1'b1;
      r_seen1 <= 1'b0;
    end else begin
      r_lvbl <= lvbl;
      if (lvbl) r_seen1 <= 1'b1;
    end
  end

  assign w_edge = r_seen1 & r_lvbl & ~lvbl;

  kiwi_edge_ff u_irq (
    .clk     (clk),
    .rst_n   (rst_n),
    .sigedge (w_edge),
    .clr     (irq_ack),
    .q       (w_q),
    .qn      (int_n)
  );

endmodule

// File: tb/tb_kiwi_snd_glue.sv
// Directed bench for kiwi_snd_glue: mixer vectors, interrupt sequencing, reset.
module tb_kiwi_snd_glue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [15:0] ch0 = '0;
  logic [9:0]  ch1 = '0;
  logic [15:0] ch2 = '0;
  logic [15:0] ch3 = '0;
  logic [7:0]  gain0 = '0, gain1 = '0, gain2 = '0, gain3 = '0;
  logic [15:0] mixed;
  logic        peak;
  logic        lvbl = 1'b1;
  logic        irq_ack = 1'b0;
  logic        int_n;

  int n_cmp = 0;
  int n_bad = 0;

  kiwi_snd_glue #(.W0(16), .W1(10), .W2(16), .W3(16)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
    .mixed(mixed), .peak(peak),
    .lvbl(lvbl), .irq_ack(irq_ack), .int_n(int_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cen pulse; returns at the following negedge with outputs settled.
  task automatic sample();
    @(negedge clk) cen = 1'b1;
    @(negedge clk) cen = 1'b0;
  endtask

  task automatic set_ch(input logic [15:0] c0, input logic [9:0] c1,
                        input logic [15:0] c2, input logic [15:0] c3,
                        input logic [7:0] g0, input logic [7:0] g1,
                        input logic [7:0] g2, input logic [7:0] g3);
    ch0 = c0; ch1 = c1; ch2 = c2; ch3 = c3;
    gain0 = g0; gain1 = g1; gain2 = g2; gain3 = g3;
  endtask

  logic saw_high;

  initial begin
    #2;
    chk("rst_mixed", 32'(mixed), 32'h0);
    chk("rst_peak",  32'(peak),  32'h0);
    chk("rst_int_n", 32'(int_n), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unity pass-through; other channels nonzero but gain 0 must vanish.
    set_ch(16'h1000, 10'h3FF, 16'h8001, 16'hFFFF, 8'h10, 8'h00, 8'h00, 8'h00);
    sample();
    chk("unity_mixed", 32'(mixed), 32'h1000);
    chk("unity_peak",  32'(peak),  32'h0);

    set_ch(16'h0000, 10'h100, 16'h0000, 16'h0000, 8'h00, 8'h08, 8'h00, 8'h00);
    sample();
    chk("align_mixed", 32'(mixed), 32'h2000);

    set_ch(16'h7000, 10'h000, 16'h0000, 16'h0000, 8'h20, 8'h00, 8'h00, 8'h00);
    sample();
    chk("possat_mixed", 32'(mixed), 32'h7FFF);
    chk("possat_peak",  32'(peak),  32'h1);
    gain0 = 8'h10;
    sample();
    chk("posrec_mixed", 32'(mixed), 32'h7000);
    chk("posrec_peak",  32'(peak),  32'h0);

    // Exact limits are representable and must not flag peak.
    set_ch(16'h7FFF, 10'h000, 16'h0000, 16'h0000, 8'h10, 8'h00, 8'h00, 8'h00);
    sample();
    chk("max_mixed", 32'(mixed), 32'h7FFF);
    chk("max_peak",  32'(peak),  32'h0);
    set_ch(16'h8000, 10'h000, 16'h0000, 16'h0000, 8'h10, 8'h00, 8'h00, 8'h00);
    sample();
    chk("min_mixed", 32'(mixed), 32'h8000);
    chk("min_peak",  32'(peak),  32'h0);

    // 256 - 64 + 256 - 48 = 400
    set_ch(16'h0100, 10'h3FF, 16'h0200, 16'hFFF0, 8'h10, 8'h10, 8'h08, 8'h30);
    sample();
    chk("mix4_mixed", 32'(mixed), 32'h0190);
    chk("mix4_peak",  32'(peak),  32'h0);

    set_ch(16'h8000, 10'h000, 16'h8000, 16'h0000, 8'h10, 8'h00, 8'h10, 8'h00);
    sample();
    chk("negsat_mixed", 32'(mixed), 32'h8000);
    chk("negsat_peak",  32'(peak),  32'h1);

    set_ch(16'h1234, 10'h055, 16'h0100, 16'h0200, 8'h10, 8'h10, 8'h10, 8'h10);
    repeat (5) @(negedge clk);
    chk("hold_mixed", 32'(mixed), 32'h8000);
    chk("hold_peak",  32'(peak),  32'h1);

    // Interrupt: falling lvbl sets on the next edge and stays until ack.
    @(negedge clk) lvbl = 1'b0;
    #1 chk("irq_pre", 32'(int_n), 32'h1);
    @(negedge clk);
    chk("irq_set", 32'(int_n), 32'h0);
    saw_high = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (int_n) saw_high = 1'b1;
    end
    chk("irq_hold100", 32'(saw_high), 32'h0);
    lvbl = 1'b1;
    @(negedge clk) lvbl = 1'b0;
    @(negedge clk);
    chk("irq_reedge", 32'(int_n), 32'h0);
    irq_ack = 1'b1;
    @(negedge clk) irq_ack = 1'b0;
    chk("irq_ack", 32'(int_n), 32'h1);
    lvbl = 1'b1;
    repeat (3) @(negedge clk);
    chk("irq_rise", 32'(int_n), 32'h1);

    // Edge and ack on the same clock: set wins.
    lvbl = 1'b0; irq_ack = 1'b1;
    @(negedge clk);
    chk("irq_coinc", 32'(int_n), 32'h0);
    @(negedge clk) irq_ack = 1'b0;
    chk("irq_coinc_clr", 32'(int_n), 32'h1);

    // Reset with interrupt pending and a saturated sample held.
    lvbl = 1'b1;
    @(negedge clk) lvbl = 1'b0;
    set_ch(16'h7000, 10'h000, 16'h0000, 16'h0000, 8'h20, 8'h00, 8'h00, 8'h00);
    sample();
    chk("pre_rst_int_n", 32'(int_n), 32'h0);
    chk("pre_rst_peak",  32'(peak),  32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst2_mixed", 32'(mixed), 32'h0);
    chk("rst2_peak",  32'(peak),  32'h0);
    chk("rst2_int_n", 32'(int_n), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_noedge", 32'(int_n), 32'h1);
    lvbl = 1'b1;
    @(negedge clk) lvbl = 1'b0;
    @(negedge clk);
    chk("rel_edge", 32'(int_n), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kiwi_snd_glue.md
KIWI_SND_GLUE -- requirements
Module: kiwi_snd_glue

Interface
REQ-001 SHALL have parameter W0, default 16: width of ch0 (FM).
REQ-002 SHALL have parameter W1, default 10: width of ch1 (PSG).
REQ-003 SHALL have parameters W2 and W3, default 16: widths of ch2 and ch3.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port cen, input, 1 bit: mixer sample enable, one clk wide.
REQ-007 SHALL have ports ch0..ch3, input, W0..W3 bits: signed two's-complement audio channels.
REQ-008 SHALL have ports gain0..gain3, input, 8 bits: unsigned gains in 4.4 fixed point (8'h10 = 1.0).
REQ-009 SHALL have port mixed, output, 16 bits: signed mixed sample.
REQ-010 SHALL have port peak, output, 1 bit: high when the current sample saturated.
REQ-011 SHALL have port lvbl, input, 1 bit: vertical blank, active low.
REQ-012 SHALL have port irq_ack, input, 1 bit: interrupt acknowledge, level, active high.
REQ-013 SHALL have port int_n, output, 1 bit: CPU interrupt request, active low.

Function
REQ-014 Each channel SHALL be sign-extended and left-aligned to 16 bits: value << (16-Wn); Wn=16 passes unchanged.
REQ-015 Each aligned channel SHALL be multiplied by its unsigned gain, giving a 24-bit signed product.
REQ-016 Each product SHALL be arithmetically shifted right by 4.
REQ-017 The four scaled terms SHALL be summed in at least 22 bits, signed, with no intermediate overflow.
REQ-018 A sum above 32767 SHALL saturate to 16'h7FFF; a sum below -32768 SHALL saturate to 16'h8000.
REQ-019 mixed and peak SHALL update only on clk edges where cen=1, from the inputs present at that edge (1-clk latency).
REQ-020 mixed and peak SHALL hold their values between cen pulses.
REQ-021 peak SHALL be 1 for exactly the samples that saturated; a non-saturating sample clears it.
REQ-022 A gain of 0 SHALL remove its channel entirely, with no rounding residue.
REQ-023 The block SHALL register lvbl each clk to detect edges.
REQ-024 On a 1->0 edge of lvbl (rising edge of ~lvbl), int_n SHALL go low on the clk edge following detection.
REQ-025 A 0->1 edge of lvbl SHALL have no effect on int_n.
REQ-026 While irq_ack=1 and no new edge is present, int_n SHALL return to 1 on the next clk edge.
REQ-027 If an edge and irq_ack occur on the same clk, set SHALL win and int_n SHALL be 0.
REQ-028 int_n SHALL remain low indefinitely until acknowledged; repeated edges while pending SHALL have no extra effect.
REQ-029 Interrupt logic SHALL NOT depend on cen.

Reset
REQ-030 While rst_n=0: mixed=0, peak=0, int_n=1, and the lvbl history register=1.
REQ-031 Reset asserted mid-sample or mid-interrupt SHALL discard pending state; no edge SHALL be inferred on release.
REQ-032 After release, a lvbl edge SHALL require a 1 sampled after reset followed by a 0.

Structure
REQ-033 A shared package kiwi_snd_pkg SHALL hold GAIN_UNITY=8'h10, FM_GAIN=8'h10, PSG_GAIN=8'h10 and the saturation limits.
REQ-034 The edge-triggered set/clear flip-flop SHALL be a sub-module named kiwi_edge_ff, with ports clk, rst_n, sigedge, clr, q, qn.
REQ-035 The mixer datapath SHALL stay in kiwi_snd_glue; the total design SHALL be 120-400 lines.

Verification
REQ-036 Unity pass-through: ch0=16'h1000, gain0=8'h10, other gains 0, one cen -> mixed=16'h1000, peak=0.
REQ-037 Alignment and attenuation: W1=10, ch1=10'h100, gain1=8'h08, others 0 -> mixed=16'h2000.
REQ-038 Positive saturation: ch0=16'h7000, gain0=8'h20 -> mixed=16'h7FFF, peak=1; next sample with gain0=8'h10 -> mixed=16'h7000, peak=0.
REQ-039 Negative saturation: ch0=ch2=16'h8000, gain0=gain2=8'h10 -> mixed=16'h8000, peak=1.
REQ-040 Hold: inputs change with cen=0 -> mixed unchanged.
REQ-041 IRQ: lvbl 1->0 -> int_n=0 one clk after detection; it stays 0 for 100 clks; irq_ack pulse -> int_n=1; lvbl 0->1 -> int_n stays 1.
REQ-042 IRQ coincidence: edge and irq_ack on the same clk -> int_n=0.
REQ-043 Reset: rst_n pulsed while int_n=0 and mixed!=0 -> int_n=1, mixed=0, peak=0 immediately.
